// File: rtl/spi_mmio_master.sv
// Memory-mapped SPI master (mode 0) with TX/RX byte FIFOs and a divided SCK; `SPI_LOOPBACK_EN adds LOOPBACK at 0x004.
// Response exactly one cycle after every request; requests always accepted, TX pushes dropped when full.
module spi_mmio_master #(
   parameter int          LGDEPTH    = 3,
   parameter logic [11:0] SCKDIV_RST = 12'd3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rq_en,
   input  logic        rq_iswrite,
   input  logic [11:0] rq_addr,
   input  logic [31:0] rq_data,
   output logic        rs_en,
   output logic [31:0] rs_data,
   output logic        spi_clk,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_csn
);
   localparam logic [1:0]  ST_IDLE    = 2'd0;
   localparam logic [1:0]  ST_LO      = 2'd1;
   localparam logic [1:0]  ST_HI      = 2'd2;
   localparam logic [11:0] A_SCKDIV   = 12'h000;
   localparam logic [11:0] A_LOOPBACK = 12'h004;
   localparam logic [11:0] A_CSMODE   = 12'h018;
   localparam logic [11:0] A_TXDATA   = 12'h048;
   localparam logic [11:0] A_RXDATA   = 12'h04C;
   localparam int               DEPTH    = 1 << LGDEPTH;
   localparam logic [LGDEPTH:0] FULL_CNT = (LGDEPTH+1)'(DEPTH);

   logic [11:0]        sckdiv, timer;
   logic [1:0]         csmode, state;
   logic [7:0]         shreg, rxsh, tx_head, rx_head;
   logic [3:0]         bitcnt;
   logic               rx_ovf, sample;
   logic               wr_req, rd_req, hi_done, last_bit;
   logic               tx_push, tx_pop, rx_push, rx_pop, tx_push_ok, rx_push_ok;
   logic               tx_full, tx_empty, rx_full, rx_empty;
   logic [31:0]        rd_val;
   logic [7:0]         tx_mem [DEPTH];
   logic [7:0]         rx_mem [DEPTH];
   logic [LGDEPTH-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic [LGDEPTH:0]   tx_cnt, rx_cnt;
   logic               unused_bits;

   assign unused_bits = ^{rq_data[31:12], shreg[7]};

   assign wr_req   = rq_en && rq_iswrite;
   assign rd_req   = rq_en && !rq_iswrite;
   assign hi_done  = (state == ST_HI) && (timer == '0);
   assign last_bit = (bitcnt == 4'd1);

   assign tx_full    = (tx_cnt == FULL_CNT);
   assign tx_empty   = (tx_cnt == '0);
   assign rx_full    = (rx_cnt == FULL_CNT);
   assign rx_empty   = (rx_cnt == '0);
   assign tx_head    = tx_mem[tx_rp];
   assign rx_head    = rx_mem[rx_rp];
   assign tx_push    = wr_req && (rq_addr == A_TXDATA);
   assign tx_push_ok = tx_push && !tx_full;
   assign tx_pop     = !tx_empty && ((state == ST_IDLE) || (hi_done && last_bit));
   assign rx_push    = hi_done && last_bit;
   assign rx_push_ok = rx_push && !rx_full;
   assign rx_pop     = rd_req && (rq_addr == A_RXDATA) && !rx_empty;

   // Full/empty come from the occupancy before this cycle, so a push into a
   // full FIFO is dropped even when a pop happens in the same cycle.
   always_ff @(posedge clk) begin
      if (tx_push_ok) tx_mem[tx_wp] <= rq_data[7:0];
      if (rx_push_ok) rx_mem[rx_wp] <= rxsh;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (tx_push_ok) tx_wp <= tx_wp + LGDEPTH'(1);
         if (tx_pop)     tx_rp <= tx_rp + LGDEPTH'(1);
         if (rx_push_ok) rx_wp <= rx_wp + LGDEPTH'(1);
         if (rx_pop)     rx_rp <= rx_rp + LGDEPTH'(1);
         tx_cnt <= tx_cnt + {{LGDEPTH{1'b0}}, tx_push_ok} - {{LGDEPTH{1'b0}}, tx_pop};
         rx_cnt <= rx_cnt + {{LGDEPTH{1'b0}}, rx_push_ok} - {{LGDEPTH{1'b0}}, rx_pop};
      end
   end

`ifdef SPI_LOOPBACK_EN
   logic loopback;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                              loopback <= 1'b0;
      else if (wr_req && rq_addr == A_LOOPBACK) loopback <= rq_data[0];
   end

   assign sample = loopback ? spi_mosi : spi_miso;
`else
   assign sample = spi_miso;
`endif

   always_comb begin
      rd_val = '0;
      case (rq_addr)
         A_SCKDIV: rd_val = {20'h0, sckdiv};
         A_CSMODE: rd_val = {30'h0, csmode};
         A_TXDATA: rd_val = {tx_full, 31'h0};
         A_RXDATA: rd_val = {rx_empty, rx_ovf, 22'h0, rx_empty ? 8'h00 : rx_head};
`ifdef SPI_LOOPBACK_EN
         A_LOOPBACK: rd_val = {31'h0, loopback};
`endif
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rs_en   <= 1'b0;
         rs_data <= '0;
         sckdiv  <= SCKDIV_RST;
         csmode  <= 2'b00;
         spi_csn <= 1'b1;
         rx_ovf  <= 1'b0;
      end else begin
         rs_en   <= rq_en;
         rs_data <= rd_req ? rd_val : '0;
         if (wr_req && rq_addr == A_SCKDIV) sckdiv <= rq_data[11:0];
         if (wr_req && rq_addr == A_CSMODE) begin
            csmode  <= rq_data[1:0];
            spi_csn <= !rq_data[1];
         end
         // An overflow in the same cycle as an RXDATA read must stay visible.
         if (rx_push && rx_full)                          rx_ovf <= 1'b1;
         else if (rd_req && rq_addr == A_RXDATA)          rx_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         timer    <= '0;
         bitcnt   <= '0;
         shreg    <= '0;
         rxsh     <= '0;
         spi_clk  <= 1'b0;
         spi_mosi <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               spi_clk <= 1'b0;
               if (!tx_empty) begin
                  shreg    <= tx_head;
                  bitcnt   <= 4'd8;
                  timer    <= sckdiv;
                  spi_mosi <= tx_head[7];
                  state    <= ST_LO;
               end
            end
            ST_LO: begin
               if (timer != '0) begin
                  timer <= timer - 12'd1;
               end else begin
                  rxsh    <= {rxsh[6:0], sample};
                  spi_clk <= 1'b1;
                  timer   <= sckdiv;
                  state   <= ST_HI;
               end
            end
            ST_HI: begin
               if (timer != '0) begin
                  timer <= timer - 12'd1;
               end else begin
                  spi_clk <= 1'b0;
                  if (last_bit) begin
                     // Chain straight into the next byte so there is no idle gap.
                     if (!tx_empty) begin
                        shreg    <= tx_head;
                        bitcnt   <= 4'd8;
                        timer    <= sckdiv;
                        spi_mosi <= tx_head[7];
                        state    <= ST_LO;
                     end else begin
                        bitcnt <= '0;
                        state  <= ST_IDLE;
                     end
                  end else begin
                     shreg    <= {shreg[6:0], 1'b0};
                     bitcnt   <= bitcnt - 4'd1;
                     spi_mosi <= shreg[6];
                     timer    <= sckdiv;
                     state    <= ST_LO;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_mmio_master.sv
// Directed bench for spi_mmio_master: register table plus hand-written SPI sequences.
module tb_spi_mmio_master;
   localparam logic [11:0] A_SCK = 12'h000;
   localparam logic [11:0] A_CS  = 12'h018;
   localparam logic [11:0] A_TX  = 12'h048;
   localparam logic [11:0] A_RX  = 12'h04C;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        rq_en = 1'b0;
   logic        rq_iswrite = 1'b0;
   logic [11:0] rq_addr = '0;
   logic [31:0] rq_data = '0;
   logic        rs_en;
   logic [31:0] rs_data;
   logic        spi_clk, spi_mosi, spi_miso, spi_csn;
   logic        miso_inv = 1'b0;
   int          n_pass = 0;
   int          n_total = 0;

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdat;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[17];

   assign spi_miso = spi_mosi ^ miso_inv;
   always #5 clk = ~clk;

   spi_mmio_master #(.LGDEPTH(3), .SCKDIV_RST(12'd3)) dut (
      .clk(clk), .resetn(resetn),
      .rq_en(rq_en), .rq_iswrite(rq_iswrite), .rq_addr(rq_addr), .rq_data(rq_data),
      .rs_en(rs_en), .rs_data(rs_data),
      .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_csn(spi_csn)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic bus(input logic wr, input logic [11:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic en);
      @(negedge clk);
      rq_en = 1'b1; rq_iswrite = wr; rq_addr = a; rq_data = d;
      @(negedge clk);
      rd = rs_data; en = rs_en;
      rq_en = 1'b0; rq_iswrite = 1'b0;
   endtask

   task automatic wr_reg(input logic [11:0] a, input logic [31:0] d);
      logic [31:0] r; logic e;
      bus(1'b1, a, d, r, e);
   endtask

   task automatic rd_reg(input logic [11:0] a, output logic [31:0] v);
      logic e;
      bus(1'b0, a, 32'h0, v, e);
   endtask

   // One byte in isolation: SCK edge count, spacing, high time and received value.
   task automatic run_byte(input logic [11:0] div, input logic [7:0] b, input logic inv, input string tag);
      int toggles = 0, highs = 0, first = -1, last = -1;
      logic prev;
      logic [31:0] v;
      miso_inv = inv;
      wr_reg(A_SCK, {20'h0, div});
      wr_reg(A_TX, {24'h0, b});
      prev = spi_clk;
      for (int i = 0; i < 16 * (int'(div) + 1) + 24; i++) begin
         @(negedge clk);
         if (spi_clk !== prev) begin
            toggles++;
            if (first < 0) first = i;
            last = i;
         end
         if (spi_clk) highs++;
         prev = spi_clk;
      end
      check({tag, "_toggles"}, 32'(toggles), 32'd16);
      check({tag, "_toggle_span"}, 32'(last - first), 32'(15 * (int'(div) + 1)));
      check({tag, "_high_cycles"}, 32'(highs), 32'(8 * (int'(div) + 1)));
      rd_reg(A_RX, v);
      check({tag, "_rx"}, v, {24'h0, inv ? ~b : b});
      rd_reg(A_RX, v);
      check({tag, "_rx_empty"}, v, 32'h8000_0000);
      miso_inv = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached after %0d checks", n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic        e;
      int          got, highs, first, last, found, toggles;
      logic        prev;

      vecs[0]  = '{1'b0, 12'h000, 32'h0,          32'h0000_0003};
      vecs[1]  = '{1'b0, 12'h018, 32'h0,          32'h0000_0000};
      vecs[2]  = '{1'b0, 12'h048, 32'h0,          32'h0000_0000};
      vecs[3]  = '{1'b0, 12'h04C, 32'h0,          32'h8000_0000};
      vecs[4]  = '{1'b0, 12'h004, 32'h0,          32'h0000_0000};
      vecs[5]  = '{1'b0, 12'h7FC, 32'h0,          32'h0000_0000};
      vecs[6]  = '{1'b1, 12'h000, 32'h000A_BCDE,  32'h0000_0000};
      vecs[7]  = '{1'b0, 12'h000, 32'h0,          32'h0000_0CDE};
      vecs[8]  = '{1'b1, 12'h018, 32'hFFFF_FFFF,  32'h0000_0000};
      vecs[9]  = '{1'b0, 12'h018, 32'h0,          32'h0000_0003};
      vecs[10] = '{1'b1, 12'h018, 32'h0,          32'h0000_0000};
      vecs[11] = '{1'b1, 12'h3FC, 32'h0000_0012,  32'h0000_0000};
      vecs[12] = '{1'b0, 12'h3FC, 32'h0,          32'h0000_0000};
      vecs[13] = '{1'b1, 12'h04C, 32'h0000_0055,  32'h0000_0000};
      vecs[14] = '{1'b0, 12'h04C, 32'h0,          32'h8000_0000};
      vecs[15] = '{1'b1, 12'h000, 32'h0,          32'h0000_0000};
      vecs[16] = '{1'b0, 12'h000, 32'h0,          32'h0000_0000};

      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("rst_rs_en", 32'(rs_en), 32'd0);
      check("rst_rs_data", rs_data, 32'h0);
      check("rst_spi_clk", 32'(spi_clk), 32'd0);
      check("rst_spi_mosi", 32'(spi_mosi), 32'd0);
      check("rst_spi_csn", 32'(spi_csn), 32'd1);

      foreach (vecs[i]) begin
         bus(vecs[i].wr, vecs[i].addr, vecs[i].wdat, v, e);
         check($sformatf("vec%0d_rs_en", i), 32'(e), 32'd1);
         check($sformatf("vec%0d_rs_data", i), v, vecs[i].exp);
      end
      check("csn_after_table", 32'(spi_csn), 32'd1);

      run_byte(12'd0, 8'hA5, 1'b0, "lb_div0");
      run_byte(12'd2, 8'h5A, 1'b1, "inv_div2");

      // Slow clock: the engine holds byte 1, the FIFO fills with 2..9, byte 10 is dropped.
      wr_reg(A_SCK, 32'h0000_0FFF);
      for (int k = 1; k <= 10; k++) wr_reg(A_TX, 32'(k));
      rd_reg(A_TX, v);
      check("tx_full_flag", v, 32'h8000_0000);
      wr_reg(A_SCK, 32'h0);
      got = 0;
      for (int i = 0; i < 6000 && got < 9; i++) begin
         rd_reg(A_RX, v);
         if (!v[31]) begin
            check($sformatf("tx_seq_rx%0d", got), v, 32'(got + 1));
            got++;
         end
      end
      check("tx_seq_count", 32'(got), 32'd9);
      repeat (60) @(negedge clk);
      rd_reg(A_RX, v);
      check("tx_seq_10th_dropped", v, 32'h8000_0000);

      // Back-to-back bytes at SCKDIV=1: 32 cycles per byte, no idle cycle between them.
      wr_reg(A_SCK, 32'd1);
      highs = 0; first = -1; last = -1;
      fork
         begin
            wr_reg(A_TX, 32'h3C);
            wr_reg(A_TX, 32'hC3);
         end
         begin
            for (int i = 0; i < 140; i++) begin
               @(negedge clk);
               if (spi_clk) begin
                  highs++;
                  if (first < 0) first = i;
                  last = i;
               end
            end
         end
      join
      check("b2b_high_cycles", 32'(highs), 32'd32);
      check("b2b_span", 32'(last - first + 1), 32'd62);
      rd_reg(A_RX, v);
      check("b2b_rx0", v, 32'h0000_003C);
      rd_reg(A_RX, v);
      check("b2b_rx1", v, 32'h0000_00C3);

      // Nine bytes into an eight-deep RX FIFO without reading.
      wr_reg(A_SCK, 32'd0);
      for (int k = 1; k <= 9; k++) wr_reg(A_TX, 32'(k));
      repeat (300) @(negedge clk);
      rd_reg(A_RX, v);
      check("ovf_first", v, 32'h4000_0001);
      for (int k = 2; k <= 8; k++) begin
         rd_reg(A_RX, v);
         check($sformatf("ovf_rx%0d", k), v, 32'(k));
      end
      rd_reg(A_RX, v);
      check("ovf_9th_discarded", v, 32'h8000_0000);

      // Chip select follows CSMODE[1] one cycle after the write.
      @(negedge clk);
      rq_en = 1'b1; rq_iswrite = 1'b1; rq_addr = A_CS; rq_data = 32'd2;
      check("csn_before_write", 32'(spi_csn), 32'd1);
      @(negedge clk);
      rq_en = 1'b0; rq_iswrite = 1'b0;
      check("csn_asserted", 32'(spi_csn), 32'd0);
      wr_reg(A_CS, 32'd0);
      check("csn_released", 32'(spi_csn), 32'd1);

      // Reset in the middle of a byte with SCK high and CS asserted.
      wr_reg(A_SCK, 32'd3);
      wr_reg(A_CS, 32'd2);
      wr_reg(A_TX, 32'hFF);
      wr_reg(A_TX, 32'h81);
      found = 0;
      prev = spi_clk;
      for (int i = 0; i < 100 && found == 0; i++) begin
         @(negedge clk);
         if (spi_clk && !prev) found = 1;
         prev = spi_clk;
      end
      check("rst_mid_sck_seen", 32'(found), 32'd1);
      rq_en = 1'b1; rq_iswrite = 1'b0; rq_addr = A_SCK;
      @(negedge clk);
      check("rst_mid_pre_rs_en", 32'(rs_en), 32'd1);
      check("rst_mid_pre_clk", 32'(spi_clk), 32'd1);
      check("rst_mid_pre_csn", 32'(spi_csn), 32'd0);
      #1;
      resetn = 1'b0;
      rq_en = 1'b0;
      #1;
      check("rst_mid_rs_en", 32'(rs_en), 32'd0);
      check("rst_mid_rs_data", rs_data, 32'h0);
      check("rst_mid_clk", 32'(spi_clk), 32'd0);
      check("rst_mid_mosi", 32'(spi_mosi), 32'd0);
      check("rst_mid_csn", 32'(spi_csn), 32'd1);
      @(negedge clk);
      resetn = 1'b1;
      rd_reg(A_TX, v);
      check("rst_mid_tx_empty", v, 32'h0);
      rd_reg(A_SCK, v);
      check("rst_mid_sckdiv", v, 32'h3);
      rd_reg(A_CS, v);
      check("rst_mid_csmode", v, 32'h0);
      toggles = 0;
      prev = spi_clk;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (spi_clk !== prev) toggles++;
         prev = spi_clk;
      end
      check("rst_mid_no_sck", 32'(toggles), 32'd0);
      rd_reg(A_RX, v);
      check("rst_mid_rx_empty", v, 32'h8000_0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
